// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, state encoding and opcode classifiers for the serial ALU
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Arithmetic ops are the only ones that propagate a carry between bits
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Opcodes above OP_SUB are undefined and report no flags at all
  function automatic logic is_defined(input logic [2:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational single-bit ALU slice
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       cin_out
);

  logic b_eff;
  logic sum;
  logic carry;

  // Full adder on B (inverted for SUB), then select the slice output by opcode
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b : b;
    sum     = a ^ b_eff ^ cin;
    carry   = (a & b_eff) | (a & cin) | (b_eff & cin);
    result  = 1'b0;
    cout    = 1'b0;
    cin_out = cin;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD, OP_SUB: begin
        result = sum;
        cout   = carry;
      end
      default: begin
        result = 1'b0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU iterating one slice from LSB to MSB
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             nz_q, nz_d;
  logic             cfin_q, cfin_d;
  logic             vfin_q, vfin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic s_res;
  logic s_cout;
  logic s_cin;

  alu_bit_slice u_slice (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .cin     (cy_q),
    .op      (op_q),
    .result  (s_res),
    .cout    (s_cout),
    .cin_out (s_cin)
  );

  // Next-state and datapath: capture in IDLE, one bit per cycle in RUN, publish in DONE
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    res_sh_d = res_sh_q;
    nz_d     = nz_q;
    cfin_d   = cfin_q;
    vfin_d   = vfin_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          cnt_d    = '0;
          cy_d     = (op == OP_SUB);
          res_sh_d = '0;
          nz_d     = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_sh_d = {s_res, res_sh_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cy_d     = s_cout;
        nz_d     = nz_q | s_res;
        if (cnt_q == LAST_BIT) begin
          cfin_d  = s_cout;
          vfin_d  = s_cin ^ s_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        result_d = res_sh_q;
        carry_d  = cfin_q;
        ovf_d    = vfin_q & is_arith(op_q);
        zero_d   = ~nz_q & is_defined(op_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      res_sh_q <= '0;
      nz_q     <= 1'b0;
      cfin_q   <= 1'b0;
      vfin_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      res_sh_q <= res_sh_d;
      nz_q     <= nz_d;
      cfin_q   <= cfin_d;
      vfin_q   <= vfin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE) | done_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - directed scoreboard bench for serial_alu
module tb_serial_alu;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic [2:0]       op_i = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             ovf;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t last_exp = '0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_i),
    .b      (b_i),
    .op     (op_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .ovf    (ovf)
  );

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    exp_t       e;
    logic [8:0] s;
    e = '0;
    s = '0;
    case (op)
      3'b000: e.result = x & y;
      3'b001: e.result = x | y;
      3'b011: e.result = x ^ y;
      3'b010: begin
        s        = {1'b0, x} + {1'b0, y};
        e.result = s[7:0];
        e.carry  = s[8];
        e.ovf    = (x[7] == y[7]) && (s[7] != x[7]);
      end
      3'b100: begin
        s        = {1'b0, x} + {1'b0, ~y} + 9'd1;
        e.result = s[7:0];
        e.carry  = s[8];
        e.ovf    = (x[7] != y[7]) && (s[7] != x[7]);
      end
      default: e.result = '0;
    endcase
    e.zero = (op <= 3'b100) && (e.result == 8'h00);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called just after a clock edge with the DUT idle; returns just after the accepting edge
  task automatic start_op(input string tag, input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back(model(op, x, y));
    a_i   = x;
    b_i   = y;
    op_i  = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i   = 8'($urandom);
    b_i   = 8'($urandom);
    op_i  = 3'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int lat, input bit chk_width);
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 3 * WIDTH) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_exp = e;
      check({tag, "_result"}, 32'(result), 32'(e.result));
      check({tag, "_carry"}, 32'(carry), 32'(e.carry));
      check({tag, "_zero"}, 32'(zero), 32'(e.zero));
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
    if (chk_width) begin
      @(posedge clk);
      #1;
      check({tag, "_done_width"}, 32'(done), 32'd0);
      check({tag, "_result_hold"}, 32'(result), 32'(last_exp.result));
    end
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    check({tag, "_no_done"}, 32'(seen), 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(last_exp.result));
  endtask

  initial begin
    exp_t dropped;
    logic [2:0] rop;

    #1 rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    start_op("add_7f_01", OP_ADD, 8'h7F, 8'h01);  wait_done("add_7f_01", 9, 1'b1);
    start_op("add_ff_01", OP_ADD, 8'hFF, 8'h01);  wait_done("add_ff_01", 9, 1'b1);
    start_op("sub_05_05", OP_SUB, 8'h05, 8'h05);  wait_done("sub_05_05", 9, 1'b1);
    start_op("sub_03_05", OP_SUB, 8'h03, 8'h05);  wait_done("sub_03_05", 9, 1'b1);
    start_op("sub_80_01", OP_SUB, 8'h80, 8'h01);  wait_done("sub_80_01", 9, 1'b1);
    start_op("and_f0_3c", OP_AND, 8'hF0, 8'h3C);  wait_done("and_f0_3c", 9, 1'b1);
    start_op("or_f0_0c", OP_OR, 8'hF0, 8'h0C);    wait_done("or_f0_0c", 9, 1'b1);
    start_op("xor_aa_aa", OP_XOR, 8'hAA, 8'hAA);  wait_done("xor_aa_aa", 9, 1'b1);
    start_op("op110", 3'b110, 8'hFF, 8'hFF);      wait_done("op110", 9, 1'b1);

    // A start pulsed mid-run with other operands must not disturb the first result
    start_op("ignore", OP_ADD, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a_i   = 8'hFF;
    b_i   = 8'hFF;
    op_i  = OP_SUB;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 5, 1'b1);
    check_quiet("ignore_after", 12);

    // Back-to-back starts spaced WIDTH+2 cycles apart
    start_op("b2b_1", OP_ADD, 8'h40, 8'h40);
    wait_done("b2b_1", 9, 1'b0);
    start_op("b2b_2", OP_SUB, 8'h10, 8'h20);
    wait_done("b2b_2", 9, 1'b1);

    for (int i = 0; i < 6; i++) begin
      case (i % 5)
        0: rop = OP_ADD;
        1: rop = OP_SUB;
        2: rop = OP_XOR;
        3: rop = OP_AND;
        default: rop = OP_OR;
      endcase
      start_op("rand", rop, 8'($urandom), 8'($urandom));
      wait_done("rand", 9, 1'b1);
    end

    // Leave nonzero flags behind so the abort visibly clears them
    start_op("pre_rst", OP_ADD, 8'hFF, 8'h01);
    wait_done("pre_rst", 9, 1'b1);
    start_op("abort", OP_ADD, 8'hC0, 8'hC0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    if (exp_q.size() > 0) dropped = exp_q.pop_front();
    last_exp = '0;
    #3 rst = 1'b0;
    check_quiet("abort_after", 12);
    start_op("post_rst", OP_SUB, 8'h80, 8'h01);
    wait_done("post_rst", 9, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
